led_blink_scheduler: RTL and testbench



---
 rtl/led_sched_pkg.sv | 32 +++
 rtl/led_blink_scheduler_prescaler.sv | 28 ++
 rtl/led_blink_scheduler.sv | 142 ++++++++++++++
 tb/tb_led_blink_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types, default timing and packed-code helper for the LED blink scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } led_state_t;

    localparam int unsigned DEF_CLK_PER_TICK = 1250;
    localparam int unsigned DEF_ON_TICKS     = 2;
    localparam int unsigned DEF_OFF_TICKS    = 2;
    localparam int unsigned DEF_GAP_TICKS    = 8;

    // Widest packed code vector the slice helper accepts.
    localparam int unsigned MAX_CODE_BITS = 256;

    // Extract field idx of a packed vector of width-bit codes.
    function automatic logic [31:0] code_slice(
        input logic [MAX_CODE_BITS-1:0] codes,
        input int unsigned              idx,
        input int unsigned              width
    );
        logic [MAX_CODE_BITS-1:0] shifted;
        logic [31:0]              mask;
        shifted = codes >> (idx * width);
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/led_blink_scheduler_prescaler.sv
// Free-running tick generator: one-cycle tick every c_CLK_PER_TICK clocks.
module led_tick_prescaler
    import led_sched_pkg::*;
#(
    parameter int unsigned c_CLK_PER_TICK = DEF_CLK_PER_TICK
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    logic [31:0] r_count;

    assign o_tick = (r_count == 32'(c_CLK_PER_TICK - 1));

    // Count up, wrapping on the tick; a clear restarts a full-length period.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of one board LED, playing each requester's blink code
// as N pulses followed by a dark gap.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned CODE_W         = 3,
    parameter int unsigned c_CLK_PER_TICK = DEF_CLK_PER_TICK,
    parameter int unsigned c_ON_TICKS     = DEF_ON_TICKS,
    parameter int unsigned c_OFF_TICKS    = DEF_OFF_TICKS,
    parameter int unsigned c_GAP_TICKS    = DEF_GAP_TICKS
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*CODE_W-1:0] i_code,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_done,
    output logic                      o_busy,
    output logic                      o_led_drive
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    led_state_t               r_state;
    logic                     r_led;
    logic [31:0]              r_phase;
    logic [IDX_W-1:0]         r_rr;
    logic [IDX_W-1:0]         r_owner;
    logic [CODE_W-1:0]        r_pulses;

    logic                     w_tick;
    logic                     w_clear;
    logic                     arb_found;
    logic [IDX_W-1:0]         arb_idx;
    logic [IDX_W-1:0]         cand;
    logic [CODE_W-1:0]        w_code;
    logic [MAX_CODE_BITS-1:0] codes_ext;
    logic [31:0]              phase_limit;
    logic                     phase_end;

    assign codes_ext   = MAX_CODE_BITS'(i_code);
    assign w_code      = CODE_W'(code_slice(codes_ext, 32'(arb_idx), CODE_W));
    assign w_clear     = (r_state == IDLE) && arb_found;
    assign phase_end   = w_tick && (r_phase == phase_limit - 32'd1);
    assign o_busy      = (r_state != IDLE);
    assign o_led_drive = r_led & i_enable;

    led_tick_prescaler #(
        .c_CLK_PER_TICK(c_CLK_PER_TICK)
    ) u_prescaler (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_clear  (w_clear),
        .o_tick   (w_tick)
    );

    // Round-robin search starting just after the last owner, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = r_rr;
        cand      = r_rr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
            if (!arb_found && i_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Tick length of the phase currently being played.
    always_comb begin
        phase_limit = 32'(c_GAP_TICKS);
        case (r_state)
            ON:      phase_limit = 32'(c_ON_TICKS);
            OFF:     phase_limit = 32'(c_OFF_TICKS);
            default: phase_limit = 32'(c_GAP_TICKS);
        endcase
    end

    // Arbitration plus pulse/off/gap sequencing with registered outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= IDLE;
            o_grant  <= '0;
            o_done   <= '0;
            r_led    <= 1'b0;
            r_phase  <= '0;
            r_rr     <= IDX_W'(NUM_REQ - 1);
            r_owner  <= '0;
            r_pulses <= '0;
        end else begin
            o_done <= '0;
            if (r_state == IDLE) begin
                r_phase <= '0;
                if (arb_found) begin
                    o_grant  <= NUM_REQ'(1) << arb_idx;
                    r_owner  <= arb_idx;
                    r_rr     <= arb_idx;
                    r_pulses <= w_code;
                    if (w_code != '0) begin
                        r_state <= ON;
                        r_led   <= 1'b1;
                    end else begin
                        r_state <= GAP;
                    end
                end
            end else if (!i_req[r_owner]) begin
                // Owner withdrew: drop the play silently; rr already points at it.
                r_state <= IDLE;
                r_led   <= 1'b0;
                o_grant <= '0;
                r_phase <= '0;
            end else if (w_tick) begin
                if (!phase_end) begin
                    r_phase <= r_phase + 32'd1;
                end else begin
                    r_phase <= '0;
                    case (r_state)
                        ON: begin
                            r_pulses <= r_pulses - CODE_W'(1);
                            r_led    <= 1'b0;
                            r_state  <= (r_pulses == CODE_W'(1)) ? GAP : OFF;
                        end
                        OFF: begin
                            r_led   <= 1'b1;
                            r_state <= ON;
                        end
                        default: begin
                            o_done  <= NUM_REQ'(1) << r_owner;
                            o_grant <= '0;
                            r_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench: directed blink-code scenarios plus randomized traffic
// against an offset-based behavioural model of a play.
module tb_led_blink_scheduler;

    localparam int unsigned N    = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned T    = 4;
    localparam int unsigned ONT  = 2;
    localparam int unsigned OFFT = 2;
    localparam int unsigned GAPT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*CW-1:0] code = '0;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          busy;
    logic          led;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        chk_en   = 1'b0;

    int unsigned cnt, hi, len, gap;
    logic [N-1:0] exp_order [5];

    always #5 clk = ~clk;

    led_blink_scheduler #(
        .NUM_REQ       (N),
        .CODE_W        (CW),
        .c_CLK_PER_TICK(T),
        .c_ON_TICKS    (ONT),
        .c_OFF_TICKS   (OFFT),
        .c_GAP_TICKS   (GAPT)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_enable   (en),
        .i_req      (req),
        .i_code     (code),
        .o_grant    (grant),
        .o_done     (done),
        .o_busy     (busy),
        .o_led_drive(led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles from now until o_done is seen, and LED-drive-high cycles before it.
    task automatic measure(input int unsigned budget, output int unsigned cycles,
                           output int unsigned high);
        cycles = 0;
        high   = 0;
        while (done == '0 && cycles < budget) begin
            high += 32'(led);
            step(1);
            cycles++;
        end
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic         active;
        logic [31:0]  owner;
        logic [31:0]  code;
        logic [31:0]  k;
        logic [31:0]  len;
        logic [31:0]  rr;
        logic [N-1:0] done;
    } mstate_t;

    mstate_t m;

    function automatic int unsigned play_len(input int unsigned c);
        if (c == 0) return GAPT * T;
        return c * ONT * T + (c - 1) * OFFT * T + GAPT * T;
    endfunction

    function automatic logic led_at(input int unsigned c, input int unsigned k);
        int unsigned per;
        per = (ONT + OFFT) * T;
        if (c == 0) return 1'b0;
        return (k < c * per - OFFT * T) && ((k % per) < ONT * T);
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s        = '0;
        s.rr     = N - 1;
        return s;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic [N-1:0] r,
                                           input logic [N*CW-1:0] c);
        mstate_t     n;
        logic        found;
        int unsigned cand;
        n      = s;
        n.done = '0;
        if (s.active) begin
            if (((r >> s.owner) & 1) == 0) n.active = 1'b0;
            else if (s.k == s.len - 1) begin
                n.active = 1'b0;
                n.done   = N'(1 << s.owner);
            end else n.k = s.k + 1;
        end else begin
            found = 1'b0;
            for (int unsigned i = 1; i <= N; i++) begin
                cand = (s.rr + i) % N;
                if (!found && ((r >> cand) & 1) != 0) begin
                    found   = 1'b1;
                    n.owner = cand;
                end
            end
            if (found) begin
                n.active = 1'b1;
                n.rr     = n.owner;
                n.k      = 0;
                n.code   = 32'((c >> (n.owner * CW)) & 12'h7);
                n.len    = play_len(n.code);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, req, code);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", 32'(grant), m.active ? 32'(1 << m.owner) : 32'd0);
            check("done",  32'(done),  32'(m.done));
            check("busy",  32'(busy),  32'(m.active));
            check("led",   32'(led),   32'(m.active && en && led_at(m.code, m.k)));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step(3);
        chk_en = 1'b1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_led",   32'(led),   32'd0);
        rst_n = 1'b1;

        // Code 3 on requester 0.
        code = 12'h003;
        req  = 4'b0001;
        step(1);
        check("t1_grant", 32'(grant), 32'd1);
        measure(200, cnt, hi);
        check("t1_done_latency", cnt, 72);
        check("t1_done_bit", 32'(done), 32'd1);
        check("t1_led_high_cycles", hi, 24);
        req = '0;
        step(1);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_grant_after", 32'(grant), 32'd0);

        // All requesting, all code 1: rotation and 40-cycle plays.
        do_reset();
        code = 12'h249;
        req  = 4'b1111;
        step(1);
        for (int g = 0; g < 5; g++) begin
            check("t2_grant_order", 32'(grant), 32'(exp_order[g]));
            len = 0;
            while (grant != '0 && len < 100) begin step(1); len++; end
            check("t2_play_len", len, 40);
            if (g < 4) begin
                gap = 0;
                while (grant == '0 && gap < 100) begin step(1); gap++; end
                check("t2_idle_gap", gap, 1);
            end
        end
        req = '0;

        // Code 0 on requester 2: gap only.
        code = '0;
        req  = 4'b0100;
        step(1);
        check("t3_grant", 32'(grant), 32'b0100);
        measure(200, cnt, hi);
        check("t3_done_latency", cnt, 32);
        check("t3_led_high_cycles", hi, 0);
        check("t3_done_bit", 32'(done), 32'b0100);
        req = '0;

        // Abort during second ON of code 5 on requester 3.
        code = 12'hA01;
        req  = 4'b1001;
        step(1);
        check("t4_grant", 32'(grant), 32'b1000);
        step(18);
        check("t4_led_second_on", 32'(led), 32'd1);
        req = 4'b0001;
        step(1);
        check("t4_abort_grant", 32'(grant), 32'd0);
        check("t4_abort_led", 32'(led), 32'd0);
        check("t4_abort_done", 32'(done), 32'd0);
        step(1);
        check("t4_next_grant", 32'(grant), 32'b0001);
        measure(200, cnt, hi);
        check("t4_next_done_latency", cnt, 40);
        req = '0;

        // LED gated off for a whole code-2 play.
        code = 12'h010;
        req  = 4'b0010;
        en   = 1'b0;
        step(1);
        check("t5_grant", 32'(grant), 32'b0010);
        measure(200, cnt, hi);
        check("t5_done_latency", cnt, 56);
        check("t5_led_high_cycles", hi, 0);
        check("t5_done_bit", 32'(done), 32'b0010);
        en  = 1'b1;
        req = '0;

        // Reset mid-OFF of a requester-3 play.
        code = 12'h401;
        req  = 4'b1000;
        step(1);
        check("t6_grant", 32'(grant), 32'b1000);
        step(10);
        check("t6_busy_mid_off", 32'(busy), 32'd1);
        req = 4'b1011;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_done",  32'(done),  32'd0);
        check("t6_async_busy",  32'(busy),  32'd0);
        check("t6_async_led",   32'(led),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        check("t6_first_after_reset", 32'(grant), 32'b0001);
        req = '0;
        step(2);

        // Randomized traffic, checked by the model every cycle.
        req  = N'($urandom);
        code = (N*CW)'($urandom);
        for (int unsigned c = 0; c < 8000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(2999) == 0) rst_n = 1'b0;
            if ($urandom_range(59) == 0) req = req ^ N'(1 << $urandom_range(N - 1));
            if ($urandom_range(99) == 0) code = (N*CW)'($urandom);
            if ($urandom_range(299) == 0) en = ~en;
            step(1);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
